// File: rtl/ikbd_pkg.sv
// ikbd_pkg: shared types and constants for the IKBD serial link.
// Holds the RX/TX state enums, frame geometry and a framing helper.
package ikbd_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SHIFT,
    TX_GAP
  } tx_state_t;

  localparam int BITS_PER_FRAME = 10;
  localparam int OVERSAMPLE     = 16;

  // 8N1 frame, wire order from bit 0: start(0), d[0..7], stop(1).
  function automatic logic [9:0] frame_of(input logic [7:0] d);
    return {1'b1, d, 1'b0};
  endfunction

endpackage

// File: rtl/ikbd_fifo.sv
// ikbd_fifo: synchronous FIFO, 2^AW entries of DW bits.
// Ports: clk_i/reset_i, push_i+din_i, pop_i, dout_o (head), level_o, full_o, empty_o.
module ikbd_fifo #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          push_i,
  input  logic [DW-1:0] din_i,
  input  logic          pop_i,
  output logic [DW-1:0] dout_o,
  output logic [AW:0]   level_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE   = (AW+1)'(1);

  logic [DW-1:0] mem_q [2**AW];
  logic [AW:0]   wr_q, wr_d;
  logic [AW:0]   rd_q, rd_d;
  logic          do_push;
  logic          do_pop;

  // Pointers carry an extra MSB so full and empty differ.
  assign level_o = wr_q - rd_q;
  assign full_o  = (level_o == DEPTH);
  assign empty_o = (level_o == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + ONE;
    if (do_pop)  rd_d = rd_q + ONE;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/ikbd_serial.sv
// ikbd_serial: IKBD side of the ACIA link; 8N1 receiver plus FIFO-fed transmitter.
// Ports: clk/reset, rx/tx lines, tx_data/tx_strobe push side with full/level/overflow/busy, rx_data/valid/frame_err.
module ikbd_serial
  import ikbd_pkg::*;
#(
  parameter int CLK_DIV_LOG2 = 12,
  parameter int FIFO_AW      = 4,
  parameter int TX_GAP_BITS  = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx,
  output logic               tx,
  input  logic [7:0]         tx_data,
  input  logic               tx_strobe,
  output logic               tx_full,
  output logic [FIFO_AW:0]   tx_level,
  output logic               tx_overflow,
  output logic               tx_busy,
  output logic [7:0]         rx_data,
  output logic               rx_valid,
  output logic               rx_frame_err
);

  localparam int          TW       = CLK_DIV_LOG2 - 4;
  localparam logic [3:0]  BIT_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]  FRM_LAST = 4'(BITS_PER_FRAME - 1);
  localparam logic [7:0]  GAP_LAST = 8'(TX_GAP_BITS * OVERSAMPLE - 1);

  // Oversample tick: one clk in every 2^TW.
  logic [TW-1:0] tick_q;
  logic          tick;

  assign tick = (tick_q == '0);

  always_ff @(posedge clk) begin
    if (reset) tick_q <= '0;
    else       tick_q <= tick_q + TW'(1);
  end

  // RX filter: also synchronises rx; output only moves on 4 equal samples.
  logic [3:0] flt_sr_q;
  logic       flt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      flt_sr_q <= 4'b1111;
      flt_q    <= 1'b1;
    end else begin
      flt_sr_q <= {flt_sr_q[2:0], rx};
      if (flt_sr_q == 4'b0000)      flt_q <= 1'b0;
      else if (flt_sr_q == 4'b1111) flt_q <= 1'b1;
    end
  end

  // RX FSM
  rx_state_t  rx_st_q;
  logic [3:0] rx_cnt_q;
  logic [2:0] rx_bit_q;
  logic [7:0] rx_sh_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q;
  logic       rx_ferr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_st_q    <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      if (tick) begin
        unique case (rx_st_q)
          RX_IDLE: begin
            if (!flt_q) begin
              rx_st_q  <= RX_START;
              rx_cnt_q <= 4'd7;
            end
          end
          RX_START: begin
            if (rx_cnt_q != '0) begin
              rx_cnt_q <= rx_cnt_q - 4'd1;
            end else if (flt_q) begin
              // line back high at mid start bit: glitch
              rx_st_q <= RX_IDLE;
            end else begin
              rx_st_q  <= RX_DATA;
              rx_cnt_q <= BIT_LAST;
              rx_bit_q <= '0;
            end
          end
          RX_DATA: begin
            if (rx_cnt_q != '0) begin
              rx_cnt_q <= rx_cnt_q - 4'd1;
            end else begin
              rx_sh_q  <= {flt_q, rx_sh_q[7:1]};
              rx_cnt_q <= BIT_LAST;
              rx_bit_q <= rx_bit_q + 3'd1;
              if (rx_bit_q == 3'd7) rx_st_q <= RX_STOP;
            end
          end
          RX_STOP: begin
            if (rx_cnt_q != '0) begin
              rx_cnt_q <= rx_cnt_q - 4'd1;
            end else begin
              if (flt_q) begin
                rx_data_q  <= rx_sh_q;
                rx_valid_q <= 1'b1;
              end else begin
                rx_ferr_q <= 1'b1;
              end
              rx_st_q <= RX_IDLE;
            end
          end
          default: rx_st_q <= RX_IDLE;
        endcase
      end
    end
  end

  // TX FIFO
  logic [7:0]       fifo_dout;
  logic [FIFO_AW:0] fifo_level;
  logic             fifo_full;
  logic             fifo_empty;
  logic             tx_load;
  logic             ovf_q;

  ikbd_fifo #(
    .AW (FIFO_AW),
    .DW (8)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (tx_strobe),
    .din_i   (tx_data),
    .pop_i   (tx_load),
    .dout_o  (fifo_dout),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= tx_strobe && fifo_full;
  end

  // TX FSM
  tx_state_t  tx_st_q;
  logic [8:0] tx_sh_q;
  logic [3:0] tx_tcnt_q;
  logic [3:0] tx_bit_q;
  logic [7:0] tx_gcnt_q;
  logic       tx_q;
  logic       busy_q;
  logic [9:0] tx_frame;
  logic       frame_end;
  logic       gap_end;

  assign tx_frame  = frame_of(fifo_dout);
  assign frame_end = (tx_st_q == TX_SHIFT) &&
                     (tx_tcnt_q == '0) &&
                     (tx_bit_q == FRM_LAST);
  assign gap_end   = (tx_st_q == TX_GAP) && (tx_gcnt_q == '0);

  // A new byte may start from idle, or directly at the end of the
  // stop bit / gap so that queued bytes leave without extra idle time.
  assign tx_load = tick && !fifo_empty &&
                   ((tx_st_q == TX_IDLE) ||
                    (frame_end && (TX_GAP_BITS == 0)) ||
                    gap_end);

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_st_q   <= TX_IDLE;
      tx_sh_q   <= '1;
      tx_tcnt_q <= '0;
      tx_bit_q  <= '0;
      tx_gcnt_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else if (tick) begin
      if (tx_load) begin
        // tx carries the bit on the wire; the shifter holds the rest
        tx_st_q   <= TX_SHIFT;
        tx_q      <= tx_frame[0];
        tx_sh_q   <= tx_frame[9:1];
        tx_tcnt_q <= BIT_LAST;
        tx_bit_q  <= '0;
        busy_q    <= 1'b1;
      end else begin
        unique case (tx_st_q)
          TX_IDLE: tx_q <= 1'b1;
          TX_SHIFT: begin
            if (tx_tcnt_q != '0) begin
              tx_tcnt_q <= tx_tcnt_q - 4'd1;
            end else if (tx_bit_q == FRM_LAST) begin
              tx_q <= 1'b1;
              if (TX_GAP_BITS > 0) begin
                tx_st_q   <= TX_GAP;
                tx_gcnt_q <= GAP_LAST;
              end else begin
                tx_st_q <= TX_IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              tx_q      <= tx_sh_q[0];
              tx_sh_q   <= {1'b1, tx_sh_q[8:1]};
              tx_tcnt_q <= BIT_LAST;
              tx_bit_q  <= tx_bit_q + 4'd1;
            end
          end
          TX_GAP: begin
            tx_q <= 1'b1;
            if (tx_gcnt_q != '0) begin
              tx_gcnt_q <= tx_gcnt_q - 8'd1;
            end else begin
              tx_st_q <= TX_IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            tx_st_q <= TX_IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tx           = tx_q;
  assign tx_full      = fifo_full;
  assign tx_level     = fifo_level;
  assign tx_overflow  = ovf_q;
  assign tx_busy      = busy_q;
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = rx_ferr_q;

endmodule
